// File: rtl/axi_riscv_amo_alu_arbiter.sv
// Round-robin arbiter sharing one registered RISC-V AMO ALU between NumReq requesters.
// A single result is held at a time; a new op is accepted in the cycle the held result handshakes.
module axi_riscv_amo_alu_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxWidth  = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*4-1:0]         req_op_i,
  input  logic [NumReq*DataWidth-1:0] req_mem_i,
  input  logic [NumReq*DataWidth-1:0] req_opnd_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [DataWidth-1:0]        rsp_result_o,
  output logic                        rsp_err_o,
  output logic                        busy_o
);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d, grant_q, grant_d, win, cand;
  logic [DataWidth-1:0]  result_q, result_d, a_sel, b_sel;
  logic                  err_q, err_d;
  logic [3:0]            op_sel;
  logic                  any_vld, handshake, can_accept, accept;

  // Returns {err, result}; illegal ops pass the old memory value through.
  function automatic logic [DataWidth:0] amo_alu(input logic [3:0] op,
                                                 input logic [DataWidth-1:0] a,
                                                 input logic [DataWidth-1:0] b);
    logic signed [DataWidth-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a & ~b};
      4'd2:    return {1'b0, a ^ b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, (sa >= sb) ? a : b};
      4'd5:    return {1'b0, (sa <= sb) ? a : b};
      4'd6:    return {1'b0, (a >= b) ? a : b};
      4'd7:    return {1'b0, (a <= b) ? a : b};
      4'd8:    return {1'b0, b};
      default: return {1'b1, a};
    endcase
  endfunction

  // Descending scan so the candidate closest after the pointer wins.
  always_comb begin
    win     = '0;
    cand    = '0;
    any_vld = 1'b0;
    for (int i = NumReq; i >= 1; i--) begin
      cand = IdxWidth'((int'(ptr_q) + i) % int'(NumReq));
      if (req_valid_i[cand]) begin
        win     = cand;
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win == IdxWidth'(i)) begin
        op_sel = req_op_i[i*4 +: 4];
        a_sel  = req_mem_i[i*DataWidth +: DataWidth];
        b_sel  = req_opnd_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign handshake  = (state_q == RESP) && rsp_ready_i[grant_q];
  assign can_accept = (state_q == IDLE) || handshake;
  assign accept     = can_accept && any_vld;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = accept && (win == IdxWidth'(i));
      rsp_valid_o[i] = (state_q == RESP) && (grant_q == IdxWidth'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    result_d = result_q;
    err_d    = err_q;
    if (accept) begin
      state_d             = RESP;
      ptr_d               = win;
      grant_d             = win;
      {err_d, result_d}   = amo_alu(op_sel, a_sel, b_sel);
    end else if (handshake) begin
      state_d = IDLE;
    end
  end

  // Result stage: one registered operation in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= IdxWidth'(NumReq - 1);
      grant_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q == RESP);

endmodule

// File: tb/tb_axi_riscv_amo_alu_arbiter.sv
// Bench for axi_riscv_amo_alu_arbiter: ALU vector table, directed arbitration sequences, random model compare.
module tb_axi_riscv_amo_alu_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   vld, rspr, req_ready, rsp_valid;
  logic [N*4-1:0] req_op;
  logic [N*W-1:0] req_mem, req_opnd;
  logic [W-1:0]   rsp_result;
  logic           rsp_err, busy;

  logic [3:0]     op_a [N];
  logic [W-1:0]   a_a  [N];
  logic [W-1:0]   b_a  [N];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_op   = '0;
    req_mem  = '0;
    req_opnd = '0;
    for (int i = 0; i < N; i++) begin
      req_op[i*4 +: 4]   = op_a[i];
      req_mem[i*W +: W]  = a_a[i];
      req_opnd[i*W +: W] = b_a[i];
    end
  end

  axi_riscv_amo_alu_arbiter #(.NumReq(N), .DataWidth(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (vld),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_mem_i   (req_mem),
    .req_opnd_i  (req_opnd),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rspr),
    .rsp_result_o(rsp_result),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference AMO semantics straight from the op definitions.
  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    case (op)
      4'd0: return {1'b0, W'(a + b)};
      4'd1: return {1'b0, a & ~b};
      4'd2: return {1'b0, a ^ b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, (sb > sa) ? b : a};
      4'd5: return {1'b0, (sb < sa) ? b : a};
      4'd6: return {1'b0, (b > a) ? b : a};
      4'd7: return {1'b0, (b < a) ? b : a};
      4'd8: return {1'b0, b};
      default: return {1'b1, a};
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 4))
      0: return 64'h8000_0000_0000_0000;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return W'($urandom_range(0, 7));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    vec_t         tbl [12];
    int           fair_g [6];
    logic [N-1:0] pend;
    int           mptr, mgrant, w;
    logic         mbusy, merr, hs, can;
    logic [W-1:0] mres;
    logic [W:0]   r;

    tbl[0]  = '{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0};
    tbl[1]  = '{4'd4,  64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b0};
    tbl[2]  = '{4'd6,  64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 1'b0};
    tbl[3]  = '{4'd5,  64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 1'b0};
    tbl[4]  = '{4'd7,  64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b0};
    tbl[5]  = '{4'd12, 64'h55, 64'hAA, 64'h55, 1'b1};
    tbl[6]  = '{4'd8,  64'h55, 64'hAA, 64'hAA, 1'b0};
    tbl[7]  = '{4'd1,  64'hF0F0, 64'h0FF0, 64'hF000, 1'b0};
    tbl[8]  = '{4'd2,  64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0};
    tbl[9]  = '{4'd3,  64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0};
    tbl[10] = '{4'd9,  64'h1234, 64'h1, 64'h1234, 1'b1};
    tbl[11] = '{4'd7,  64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
    fair_g = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0;
    vld   = '0;
    rspr  = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      a_a[i]  = '0;
      b_a[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_result", rsp_result, '0);
    chk("rst_err", W'(rsp_err), '0);
    rst_n = 1'b1;

    // Fairness: everyone valid, results always accepted.
    for (int i = 0; i < N; i++) begin
      op_a[i] = 4'd0;
      a_a[i]  = W'(i);
      b_a[i]  = 64'd100;
    end
    vld  = '1;
    rspr = '1;
    #1;
    chk("fair_ready0", W'(req_ready), W'(4'b0001));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("fair_rsp_valid", W'(rsp_valid), W'(4'b0001 << fair_g[k]));
      chk("fair_result", rsp_result, W'(fair_g[k] + 100));
      if (k < 5) chk("fair_ready", W'(req_ready), W'(4'b0001 << fair_g[k+1]));
    end
    vld = '0;
    @(posedge clk); #1;
    chk("fair_drain_valid", W'(rsp_valid), '0);
    chk("fair_drain_busy", W'(busy), '0);
    rspr = '0;

    // Backpressure: req2 held for 5 cycles while req1 waits.
    op_a[2] = 4'd0; a_a[2] = 64'h200; b_a[2] = 64'h1;
    op_a[1] = 4'd8; a_a[1] = 64'h7;   b_a[1] = 64'h1BB;
    vld = 4'b0110;
    #1;
    chk("bp_ready_first", W'(req_ready), W'(4'b0100));
    @(posedge clk); #1;
    vld = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", W'(rsp_valid), W'(4'b0100));
      chk("bp_result", rsp_result, 64'h201);
      chk("bp_ready", W'(req_ready), '0);
      @(posedge clk); #1;
    end
    rspr = 4'b0100;
    #1;
    chk("bp_ready_release", W'(req_ready), W'(4'b0010));
    @(posedge clk); #1;
    vld = '0;
    chk("bp_next_valid", W'(rsp_valid), W'(4'b0010));
    chk("bp_next_result", rsp_result, 64'h1BB);
    rspr = 4'b0010;
    @(posedge clk); #1;
    chk("bp_idle", W'(rsp_valid), '0);
    rspr = '0;

    // ALU table on requester 0.
    for (int t = 0; t < 12; t++) begin
      op_a[0] = tbl[t].op;
      a_a[0]  = tbl[t].a;
      b_a[0]  = tbl[t].b;
      vld     = 4'b0001;
      #1;
      chk("tbl_ready", W'(req_ready), W'(4'b0001));
      @(posedge clk); #1;
      vld = '0;
      chk("tbl_rsp_valid", W'(rsp_valid), W'(4'b0001));
      chk("tbl_result", rsp_result, tbl[t].res);
      chk("tbl_err", W'(rsp_err), W'(tbl[t].err));
      rspr = 4'b0001;
      @(posedge clk); #1;
      chk("tbl_idle_valid", W'(rsp_valid), '0);
      chk("tbl_idle_hold", rsp_result, tbl[t].res);
      rspr = '0;
    end

    // Reset while a result is held.
    op_a[0] = 4'd0; a_a[0] = 64'd1; b_a[0] = 64'd1;
    op_a[3] = 4'd8; a_a[3] = 64'd0; b_a[3] = 64'h33;
    vld = 4'b0001;
    @(posedge clk); #1;
    vld = '0;
    chk("rmid_busy_before", W'(busy), W'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rmid_valid", W'(rsp_valid), '0);
    chk("rmid_busy", W'(busy), '0);
    chk("rmid_result", rsp_result, '0);
    vld = 4'b1001;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rmid_ready_after", W'(req_ready), W'(4'b0001));
    @(posedge clk); #1;
    chk("rmid_grant0", W'(rsp_valid), W'(4'b0001));
    chk("rmid_result2", rsp_result, 64'd2);
    vld  = '0;
    rspr = 4'b0001;
    @(posedge clk); #1;
    rspr = '0;

    // Random traffic against a transaction-level model.
    mptr = 0; mgrant = 0; mbusy = 1'b0; mres = 64'd2; merr = 1'b0;
    pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          vld[i]  = ($urandom_range(0, 2) != 0);
          op_a[i] = 4'($urandom_range(0, 15));
          a_a[i]  = rnd64();
          b_a[i]  = ($urandom_range(0, 5) == 0) ? a_a[i] : rnd64();
        end
      end
      rspr = N'($urandom);
      #1;
      hs  = mbusy && rspr[mgrant];
      can = !mbusy || hs;
      w   = rr_pick(vld, mptr);
      chk("rnd_ready", W'(req_ready), (can && w >= 0) ? W'(4'b0001 << w) : '0);
      chk("rnd_rsp_valid", W'(rsp_valid), mbusy ? W'(4'b0001 << mgrant) : '0);
      chk("rnd_result", rsp_result, mres);
      chk("rnd_err", W'(rsp_err), W'(merr));
      chk("rnd_busy", W'(busy), W'(mbusy));
      @(posedge clk); #1;
      pend = vld;
      if (can && w >= 0) begin
        r       = ref_alu(op_a[w], a_a[w], b_a[w]);
        mres    = r[W-1:0];
        merr    = r[W];
        mbusy   = 1'b1;
        mgrant  = w;
        mptr    = w;
        pend[w] = 1'b0;
      end else if (hs) begin
        mbusy = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
